seg7_scan_reader: RTL and testbench



---
 rtl/seg7_scan_reader_if.sv | 24 ++
 rtl/seg7_scan_reader.sv | 136 +++++++++++++
 tb/tb_seg7_scan_reader.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_reader_if.sv
// Signal bundle for the multiplexed 7-segment reader: the scanned segment bus in,
// and the decoded frame out through a valid/ready handshake.
interface seg7_scan_reader_if #(
    parameter int NDIG = 4
);
    logic [6:0]        led;
    logic [NDIG-1:0]   dig_en;
    logic              frame_ready;
    logic [4*NDIG-1:0] bcd_out;
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   err;
    logic              frame_valid;
    logic              overrun;

    modport master (
        output led, dig_en, frame_ready,
        input  bcd_out, blank, err, frame_valid, overrun
    );

    modport slave (
        input  led, dig_en, frame_ready,
        output bcd_out, blank, err, frame_valid, overrun
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// Samples a multiplexed 7-segment bus, debounces each digit, decodes it back to BCD
// and publishes complete frames through a valid/ready handshake.
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_reader_if.slave bus
);
    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [6:0]        led_q_reg, led_prev_reg;
    logic [NDIG-1:0]   dig_q_reg, dig_prev_reg;
    logic [3:0]        cnt_reg, cnt_next;
    logic [NDIG-1:0]   seen_reg, seen_next;
    logic [NDIG-1:0]   cap_mask;
    logic              one_hot, same_sample, capture, frame_done;
    logic [3:0]        dec_bcd;
    logic              dec_blank, dec_err;

    logic [3:0]        work_bcd_reg   [NDIG];
    logic              work_blank_reg [NDIG];
    logic              work_err_reg   [NDIG];
    logic [4*NDIG-1:0] work_bcd_flat;
    logic [NDIG-1:0]   work_blank_flat, work_err_flat;

    logic [4*NDIG-1:0] snap_bcd_reg;
    logic [NDIG-1:0]   snap_blank_reg, snap_err_reg;
    logic              valid_reg, overrun_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q_reg    <= '0;
            dig_q_reg    <= '0;
            led_prev_reg <= '0;
            dig_prev_reg <= '0;
            cnt_reg      <= '0;
            seen_reg     <= '0;
        end else begin
            led_q_reg    <= bus.led;
            dig_q_reg    <= bus.dig_en;
            led_prev_reg <= led_q_reg;
            dig_prev_reg <= dig_q_reg;
            cnt_reg      <= cnt_next;
            seen_reg     <= seen_next;
        end
    end

    always_comb begin
        one_hot     = (dig_q_reg != '0) && ((dig_q_reg & (dig_q_reg - NDIG'(1))) == '0);
        same_sample = (led_q_reg == led_prev_reg) && (dig_q_reg == dig_prev_reg);
        cnt_next    = '0;
        if (one_hot) begin
            if (!same_sample)
                cnt_next = 4'd1;
            else if (cnt_reg == STABLE_C)
                cnt_next = cnt_reg;
            else
                cnt_next = cnt_reg + 4'd1;
        end
        // A saturated counter stays at STABLE, so each dwell produces exactly one capture.
        capture    = one_hot && (cnt_reg == STABLE_C - 4'd1) && (cnt_next == STABLE_C);
        cap_mask   = capture ? dig_q_reg : '0;
        frame_done = &seen_reg;
        // A capture landing on the completion edge starts the next frame.
        seen_next  = frame_done ? cap_mask : (seen_reg | cap_mask);
    end

    always_comb begin
        dec_bcd   = 4'd0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (led_q_reg)
            7'h7E: dec_bcd = 4'd0;
            7'h30: dec_bcd = 4'd1;
            7'h6D: dec_bcd = 4'd2;
            7'h79: dec_bcd = 4'd3;
            7'h33: dec_bcd = 4'd4;
            7'h5B: dec_bcd = 4'd5;
            7'h5F: dec_bcd = 4'd6;
            7'h70: dec_bcd = 4'd7;
            7'h7F: dec_bcd = 4'd8;
            7'h7B: dec_bcd = 4'd9;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        always_ff @(posedge clk) begin
            if (rst) begin
                work_bcd_reg[gi]   <= '0;
                work_blank_reg[gi] <= 1'b0;
                work_err_reg[gi]   <= 1'b0;
            end else if (cap_mask[gi]) begin
                work_bcd_reg[gi]   <= dec_bcd;
                work_blank_reg[gi] <= dec_blank;
                work_err_reg[gi]   <= dec_err;
            end
        end
        assign work_bcd_flat[4*gi +: 4] = work_bcd_reg[gi];
        assign work_blank_flat[gi]      = work_blank_reg[gi];
        assign work_err_flat[gi]        = work_err_reg[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_bcd_reg   <= '0;
            snap_blank_reg <= '0;
            snap_err_reg   <= '0;
            valid_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (frame_done) begin
                if (!valid_reg || bus.frame_ready) begin
                    snap_bcd_reg   <= work_bcd_flat;
                    snap_blank_reg <= work_blank_flat;
                    snap_err_reg   <= work_err_flat;
                    valid_reg      <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && bus.frame_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign bus.bcd_out     = snap_bcd_reg;
    assign bus.blank       = snap_blank_reg;
    assign bus.err         = snap_err_reg;
    assign bus.frame_valid = valid_reg;
    assign bus.overrun     = overrun_reg;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (NDIG=4, STABLE=3): scans digit patterns
// and compares the published frames against hand-computed values.
module tb_seg7_scan_reader;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   ovr_cnt;

    seg7_scan_reader_if #(.NDIG(4)) bus ();

    seg7_scan_reader #(.NDIG(4), .STABLE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.overrun) ovr_cnt++;
    endtask

    task automatic show(input int d, input logic [6:0] pat, input int n);
        bus.dig_en = 4'(1) << d;
        bus.led    = pat;
        $display("digit %0d led %h dwell %0d", d, pat, n);
        repeat (n) step();
    endtask

    task automatic idle(input int n);
        bus.dig_en = '0;
        repeat (n) step();
    endtask

    task automatic wait_fv(input string tag, input int lim);
        int k;
        k = 0;
        while (!bus.frame_valid && k < lim) begin
            step();
            k++;
        end
        check(tag, 32'(bus.frame_valid), 32'd1);
    endtask

    task automatic release_frame(input string tag);
        bus.frame_ready = 1'b1;
        step();
        check(tag, 32'(bus.frame_valid), 32'd0);
        bus.frame_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ovr_cnt  = 0;
        rst      = 1'b1;
        bus.led  = '0;
        bus.dig_en = '0;
        bus.frame_ready = 1'b0;
        repeat (3) step();
        check("reset_bcd",   32'(bus.bcd_out), 32'h0);
        check("reset_blank", 32'(bus.blank), 32'h0);
        check("reset_err",   32'(bus.err), 32'h0);
        check("reset_fv",    32'(bus.frame_valid), 32'h0);
        check("reset_ovr",   32'(bus.overrun), 32'h0);
        rst = 1'b0;
        step();

        // Frame 1234 with frame_ready held high: valid for exactly one cycle.
        bus.frame_ready = 1'b1;
        show(0, 7'h30, 5);
        show(1, 7'h6D, 5);
        show(2, 7'h79, 5);
        show(3, 7'h33, 4);
        check("t1_fv_at_capture", 32'(bus.frame_valid), 32'd0);
        step();
        check("t1_fv_high",  32'(bus.frame_valid), 32'd1);
        check("t1_bcd",      32'(bus.bcd_out), 32'h4321);
        check("t1_blank",    32'(bus.blank), 32'h0);
        check("t1_err",      32'(bus.err), 32'h0);
        step();
        check("t1_fv_low",   32'(bus.frame_valid), 32'd0);
        idle(3);

        // A short 8 glitch before a 9 on digit 2 must decode as 9.
        bus.frame_ready = 1'b0;
        show(0, 7'h5B, 5);
        show(1, 7'h30, 5);
        show(2, 7'h7F, 2);
        show(2, 7'h7B, 4);
        show(3, 7'h70, 5);
        wait_fv("t2_fv", 10);
        check("t2_bcd", 32'(bus.bcd_out), 32'h7915);
        release_frame("t2_release");

        // Digit 2 held only STABLE-1 cycles: no frame until it is shown properly.
        show(0, 7'h7E, 5);
        show(1, 7'h5F, 5);
        show(2, 7'h30, 2);
        show(3, 7'h79, 5);
        idle(10);
        check("t2_short_dwell_no_frame", 32'(bus.frame_valid), 32'd0);
        show(2, 7'h6D, 5);
        wait_fv("t2b_fv", 10);
        check("t2b_bcd", 32'(bus.bcd_out), 32'h3260);
        release_frame("t2b_release");

        // Error and blank patterns.
        show(0, 7'h33, 5);
        show(1, 7'h01, 5);
        show(2, 7'h7B, 5);
        show(3, 7'h00, 5);
        wait_fv("t3_fv", 10);
        check("t3_bcd",   32'(bus.bcd_out), 32'h0904);
        check("t3_err",   32'(bus.err), 32'h2);
        check("t3_blank", 32'(bus.blank), 32'h8);
        release_frame("t3_release");
        check("t1_t3_no_overrun", 32'(ovr_cnt), 32'd0);

        // Back-pressure across two frames: second one is dropped.
        ovr_cnt = 0;
        show(0, 7'h30, 5);
        show(1, 7'h6D, 5);
        show(2, 7'h79, 5);
        show(3, 7'h33, 5);
        wait_fv("t4_fv", 10);
        check("t4_bcd_first", 32'(bus.bcd_out), 32'h4321);
        show(0, 7'h5B, 5);
        show(1, 7'h5F, 5);
        show(2, 7'h70, 5);
        show(3, 7'h7F, 5);
        idle(3);
        check("t4_overrun_count", 32'(ovr_cnt), 32'd1);
        check("t4_bcd_held", 32'(bus.bcd_out), 32'h4321);
        check("t4_fv_held",  32'(bus.frame_valid), 32'd1);
        release_frame("t4_release");

        // Multi-hot and empty strobes must neither capture nor clear progress.
        show(0, 7'h5F, 5);
        show(1, 7'h70, 5);
        bus.dig_en = 4'b0011;
        bus.led    = 7'h7E;
        repeat (10) step();
        bus.dig_en = 4'b0000;
        repeat (10) step();
        check("t5_no_frame", 32'(bus.frame_valid), 32'd0);
        show(2, 7'h7F, 5);
        show(3, 7'h7B, 5);
        wait_fv("t5_fv", 10);
        check("t5_bcd", 32'(bus.bcd_out), 32'h9876);

        // Reset mid-scan with a frame still pending.
        show(0, 7'h7F, 5);
        show(1, 7'h7B, 5);
        show(2, 7'h7E, 5);
        rst = 1'b1;
        bus.dig_en = '0;
        step();
        rst = 1'b0;
        check("t6_rst_bcd",   32'(bus.bcd_out), 32'h0);
        check("t6_rst_blank", 32'(bus.blank), 32'h0);
        check("t6_rst_err",   32'(bus.err), 32'h0);
        check("t6_rst_fv",    32'(bus.frame_valid), 32'h0);
        check("t6_rst_ovr",   32'(bus.overrun), 32'h0);
        show(3, 7'h5B, 5);
        idle(5);
        check("t6_partial_discarded", 32'(bus.frame_valid), 32'd0);
        show(0, 7'h7F, 5);
        show(1, 7'h7B, 5);
        show(2, 7'h7E, 5);
        wait_fv("t6_fv", 10);
        check("t6_bcd",   32'(bus.bcd_out), 32'h5098);
        check("t6_blank", 32'(bus.blank), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
